// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit and the control unit that drives it.
// Holds the FSM encoding, the default operand width and the MIPS funct codes.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MULT_RUN = 3'd1;
  localparam logic [2:0] ST_DIV_RUN  = 3'd2;
  localparam logic [2:0] ST_DIV_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // funct field values decoded by the control unit for R-type mult/div
  localparam logic [5:0] MULT_F = 6'b011000;
  localparam logic [5:0] DIV_F  = 6'b011010;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one quotient bit per enabled cycle.
// Quotient bits shift into the register that initially holds the dividend.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction is one bit wider so the borrow decides restore vs. keep.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (enable) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// responder for the MIPS control unit; HI/LO only change when a result completes.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH:0]   addend, booth_sum;
  logic             div_load, div_en;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic             last_step;

  assign abs_a     = a[WIDTH-1] ? -a : a;
  assign abs_b     = b[WIDTH-1] ? -b : b;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .enable    (div_en),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // Accumulator is one bit wider so subtracting -2^(WIDTH-1) cannot overflow.
  always_comb begin
    case ({mplr_q[0], qm1_q})
      2'b01:   addend = mcand_q;
      2'b10:   addend = -mcand_q;
      default: addend = '0;
    endcase
    booth_sum = acc_q + addend;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    qm1_d    = qm1_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div_load = 1'b0;
    div_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          mcand_d = {a[WIDTH-1], a};
          mplr_d  = b;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = ST_MULT_RUN;
        end else if (start_div) begin
          if (b == '0) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            div_load = 1'b1;
            negq_d   = a[WIDTH-1] ^ b[WIDTH-1];
            negr_d   = a[WIDTH-1];
            cnt_d    = '0;
            dz_d     = 1'b0;
            state_d  = ST_DIV_RUN;
          end
        end
      end
      ST_MULT_RUN: begin
        acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mplr_d = {booth_sum[0], mplr_q[WIDTH-1:1]};
        qm1_d  = mplr_q[0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_step) begin
          hi_d    = booth_sum[WIDTH:1];
          lo_d    = {booth_sum[0], mplr_q[WIDTH-1:1]};
          state_d = ST_DONE;
        end
      end
      ST_DIV_RUN: begin
        div_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_step) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        lo_d    = negq_q ? -quo : quo;
        hi_d    = negr_q ? -rem : rem;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      qm1_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      qm1_q   <= qm1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign div_zero = done & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, div-by-zero,
// reset abort and start arbitration, with hand-computed expectations.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        startMult, startDiv;
  logic [31:0] opA, opB;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int testCount = 0;
  int failCount = 0;
  int latency   = 0;

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (startMult),
    .start_div  (startDiv),
    .a          (opA),
    .b          (opB),
    .busy       (busy),
    .done       (done),
    .div_zero   (divZero),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // advance one clock and sample just after the edge
  task automatic stepCycle();
    @(posedge clock);
    #1;
    latency++;
  endtask

  // present a start for exactly one edge, then scramble the operands
  task automatic applyStimulus(input logic doMult, input logic doDiv, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    startMult = doMult;
    startDiv  = doDiv;
    opA       = av;
    opB       = bv;
    @(posedge clock);
    #1;
    startMult = 1'b0;
    startDiv  = 1'b0;
    opA       = $urandom;
    opB       = $urandom;
    latency   = 1;
  endtask

  task automatic waitDone(input string tag);
    while (!done && latency < 80) stepCycle();
    checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic runOp(input string tag, input logic doMult, input logic doDiv,
                       input logic [31:0] av, input logic [31:0] bv, input int expLat,
                       input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz);
    applyStimulus(doMult, doDiv, av, bv);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone(tag);
    checkOutput({tag, "_lat"}, 32'(latency), 32'(expLat));
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_lo"}, lo, expLo);
    checkOutput({tag, "_dz"}, 32'(divZero), 32'(expDz));
    stepCycle();
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int doneSeen;
    reset     = 1'b0;
    startMult = 1'b0;
    startDiv  = 1'b0;
    opA       = '0;
    opB       = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dz", 32'(divZero), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    runOp("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("mul_minsq", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0);
    runOp("div_m7d2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
    runOp("mul_5x6", 1'b1, 1'b0, 32'd5, 32'd6, 33, 32'd0, 32'd30, 1'b0);
    runOp("div_by0", 1'b0, 1'b1, 32'd9, 32'd0, 1, 32'd0, 32'd30, 1'b1);

    // abort a divide with reset mid-run; no done may follow
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (8) stepCycle();
    @(negedge clock);
    reset = 1'b0;
    stepCycle();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      stepCycle();
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

    // both starts together: mult wins; a later start_div mid-run is dropped
    applyStimulus(1'b1, 1'b1, 32'd123, 32'hFFFFFFD3);
    repeat (9) stepCycle();
    @(negedge clock);
    startDiv = 1'b1;
    opA      = 32'd1;
    opB      = 32'd0;
    stepCycle();
    startDiv = 1'b0;
    checkOutput("arb_busy", 32'(busy), 32'd1);
    waitDone("arb");
    checkOutput("arb_lat", 32'(latency), 32'd33);
    checkOutput("arb_hi", hi, 32'hFFFFFFFF);
    checkOutput("arb_lo", lo, 32'hFFFFEA61);
    checkOutput("arb_dz", 32'(divZero), 32'd0);
    doneSeen = 0;
    repeat (40) begin
      stepCycle();
      if (done) doneSeen++;
    end
    checkOutput("arb_no_queue", 32'(doneSeen), 32'd0);
    checkOutput("arb_hold_lo", lo, 32'hFFFFEA61);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide responder for the multicycle MIPS datapath.
- Control unit pulses a start; this block runs its algorithm and answers with a one-cycle done, the HI/LO results, and a divide-by-zero flag.
- Serves the control unit's MULT_1/MULT_WAIT/MULT_2, DIV_1/DIV_WAIT/DIV_2 and DIVBY0 sequences.
- HI/LO outputs feed the HI and LO registers (write enables HIWrite/LOWrite).

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clock)
- start_mult  input  1  one-cycle request: signed a*b
- start_div  input  1  one-cycle request: signed a/b
- a  input  WIDTH  operand A (rs); sampled only in the start cycle
- b  input  WIDTH  operand B (rt); sampled only in the start cycle
- busy  output  1  high from the cycle after start is accepted until done inclusive
- done  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle pulse coincident with done when divisor was 0
- hi  output  WIDTH  mult: product[63:32]; div: remainder
- lo  output  WIDTH  mult: product[31:0]; div: quotient

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. This also aborts any operation in flight; no done is issued for it.
- FSM states: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- IDLE:
  - start_mult=1: latch a and b, clear accumulator, counter=0, go to MULT_RUN.
  - start_div=1 with b!=0: latch |a|, |b| and the operand signs, go to DIV_RUN.
  - start_div=1 with b==0: go directly to DONE with div_zero set; hi/lo unchanged.
  - Both starts high in the same cycle: start_mult wins.
- MULT_RUN: radix-2 Booth, one step per cycle, exactly WIDTH cycles. Then go to DONE, loading {hi,lo} with the 2*WIDTH signed product.
- DIV_RUN: unsigned restoring division on magnitudes, one quotient bit per cycle, exactly WIDTH cycles.
- DIV_FIX (1 cycle): apply signs.
  - Quotient is negated when the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - hi/lo are loaded on exit to DONE.
- DONE: done=1 for exactly one cycle (div_zero=1 as well if applicable), then return to IDLE.
- Latency, with start sampled at edge k:
  - mult: done high in cycle k+33.
  - div: done high in cycle k+34.
  - div by zero: done high in cycle k+1.
- hi/lo hold their last results until the next completed non-zero-divisor operation or reset; they never show intermediate values.
- Starts received while not in IDLE (including during DONE) are ignored and never queued.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag raised (matches MIPS: result unpredictable, no trap).
- Changes on a and b after the start cycle have no effect.

Decomposition:
- Shared package md_pkg holds:
  - the FSM state encoding (3-bit localparams);
  - WIDTH default;
  - MIPS funct constants MULT_F=6'b011000 and DIV_F=6'b011010, so the control unit and this block use one source.
- One sub-module, div_core: the unsigned restoring-division iteration.
  - Inputs: load, dividend, divisor. Outputs: quotient, remainder, one step per enable.
  - Keeps sign handling and the FSM in the parent.

Test Plan:
- Mult a=7, b=0xFFFFFFFD (-3) -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0, busy low the cycle after done.
- Mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Div a=0xFFFFFFF9 (-7), b=2 -> done at start+34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Div by zero:
  - First run mult 5*6 (hi=0, lo=30).
  - Then div a=9, b=0 -> done and div_zero both high at start+1; hi=0, lo=30 unchanged.
- Robustness:
  - Start a div, drive reset=0 at cycle start+10 -> busy=0, hi=lo=0, no done.
  - Then issue start_mult and start_div together plus a second start mid-run -> only the mult runs; its result is correct at start+33.
